// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply, divide, multiply-add and multiply-subtract
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [2:0]         op_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic [WIDTH-1:0]   hi_i,
    input  logic [WIDTH-1:0]   lo_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               div_by_zero_o
);
    localparam int N  = WIDTH / STEP;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic               s1_q, s1_d, s2_q, s2_d, dz_q, dz_d, dbz_q, dbz_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, work_q, work_d, result_q, result_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               accept, is_div_i, dz_i, s1_i, s2_i, is_div_q;
    logic [WIDTH-1:0]   abs1, abs2, quo, rem;
    logic [2*WIDTH-1:0] step_w, prod, fix_res;
    logic [WIDTH:0]     step_t;
    logic               step_ge;

    assign accept   = (state_q == IDLE || state_q == DONE) && start_i && !annul_i;
    assign is_div_i = op_i[2:1] == 2'b01;
    assign dz_i     = is_div_i && opdata2_i == '0;
    assign s1_i     = op_i[0] && opdata1_i[WIDTH-1];
    assign s2_i     = op_i[0] && opdata2_i[WIDTH-1];
    assign abs1     = s1_i ? -opdata1_i : opdata1_i;
    assign abs2     = s2_i ? -opdata2_i : opdata2_i;
    assign is_div_q = mode_q == 2'b01;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= '0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            dz_q     <= 1'b0;
            dbz_q    <= 1'b0;
            acc_q    <= '0;
            work_q   <= '0;
            result_q <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            dz_q     <= dz_d;
            dbz_q    <= dbz_d;
            acc_q    <= acc_d;
            work_q   <= work_d;
            result_q <= result_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        if (!annul_i) begin
            unique case (state_q)
                IDLE, DONE: state_d = accept ? (dz_i ? FIXUP : BUSY) : IDLE;
                BUSY:       state_d = cnt_q == CW'(1) ? FIXUP : BUSY;
                FIXUP:      state_d = DONE;
                default:    state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        ready_o = state_q == DONE;
        busy_o  = state_q == BUSY || state_q == FIXUP;
    end

    // Mult keeps {partial_hi, multiplier}; div keeps {remainder, dividend/quotient}.
    always_comb begin
        step_w  = work_q;
        step_t  = '0;
        step_ge = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            if (is_div_q) begin
                step_t  = {step_w[2*WIDTH-1:WIDTH], step_w[WIDTH-1]};
                step_ge = step_t >= {1'b0, b_q};
                step_w  = {step_ge ? WIDTH'(step_t - {1'b0, b_q}) : step_t[WIDTH-1:0],
                           step_w[WIDTH-2:0], step_ge};
            end else begin
                step_t = {1'b0, step_w[2*WIDTH-1:WIDTH]} + (step_w[0] ? {1'b0, b_q} : '0);
                step_w = {step_t, step_w[WIDTH-1:1]};
            end
        end
    end

    always_comb begin
        quo     = work_q[WIDTH-1:0];
        rem     = work_q[2*WIDTH-1:WIDTH];
        prod    = (s1_q ^ s2_q) ? -work_q : work_q;
        fix_res = dz_q ? {work_q[WIDTH-1:0], {WIDTH{1'b1}}}
                : is_div_q ? {s1_q ? -rem : rem, (s1_q ^ s2_q) ? -quo : quo}
                : mode_q == 2'b10 ? acc_q + prod
                : mode_q == 2'b11 ? acc_q - prod
                : prod;
    end

    always_comb begin
        mode_d   = mode_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        dz_d     = dz_q;
        acc_d    = acc_q;
        b_d      = b_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        dbz_d    = dbz_q;
        if (state_q == BUSY) begin
            work_d = step_w;
            cnt_d  = cnt_q - CW'(1);
        end
        if (accept) begin
            mode_d = op_i[2:1];
            s1_d   = s1_i;
            s2_d   = s2_i;
            dz_d   = dz_i;
            acc_d  = {hi_i, lo_i};
            b_d    = is_div_i ? abs2 : abs1;
            work_d = {{WIDTH{1'b0}}, dz_i ? opdata1_i : (is_div_i ? abs1 : abs2)};
            cnt_d  = CW'(N);
        end
        if (state_q == FIXUP && !annul_i) begin
            result_d = fix_res;
            dbz_d    = dz_q;
        end
    end

    assign result_o      = result_q;
    assign div_by_zero_o = dbz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector check of muldiv_unit at STEP=1 and STEP=4
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [2:0]  op_i = '0;
    logic [31:0] opdata1_i = '0, opdata2_i = '0, hi_i = '0, lo_i = '0;
    logic [63:0] res1, res4;
    logic        rdy1, bsy1, dz1, rdy4, bsy4, dz4;
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32), .STEP(1)) u_dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .hi_i(hi_i), .lo_i(lo_i),
        .annul_i(annul_i), .result_o(res1), .ready_o(rdy1), .busy_o(bsy1),
        .div_by_zero_o(dz1)
    );

    muldiv_unit #(.WIDTH(32), .STEP(4)) u_dut4 (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .hi_i(hi_i), .lo_i(lo_i),
        .annul_i(annul_i), .result_o(res4), .ready_o(rdy4), .busy_o(bsy4),
        .div_by_zero_o(dz4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, b, hi, lo);
        op_i = op;
        opdata1_i = a;
        opdata2_i = b;
        hi_i = hi;
        lo_i = lo;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Ignored start and scrambled operands mid-flight prove the latched copies are used.
    task automatic run(input string tag, input bit b2b, input logic [2:0] op,
                       input logic [31:0] a, b, hi, lo, input logic [63:0] exp,
                       input int exp_lat, input bit exp_dz);
        int lat, nb;
        if (!b2b) @(negedge clk);
        issue(op, a, b, hi, lo);
        lat = 1;
        nb = 0;
        while (!rdy1 && lat < 100) begin
            nb += int'(bsy1);
            if (lat == 3) begin
                start_i = 1'b1;
                opdata1_i = ~a;
                opdata2_i = ~b;
                hi_i = ~hi;
            end
            if (lat == 4) start_i = 1'b0;
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy_cycles"}, 64'(nb), 64'(exp_lat - 1));
        check({tag, "_res"}, res1, exp);
        check({tag, "_dz"}, 64'(dz1), 64'(exp_dz));
    endtask

    initial begin
        int lat, pulses;
        repeat (3) @(negedge clk);
        check("rst_res", res1, 64'h0);
        check("rst_ready", 64'(rdy1), 64'h0);
        check("rst_busy", 64'(bsy1), 64'h0);
        check("rst_dz", 64'(dz1), 64'h0);
        rst = 1'b0;

        run("mult",     0, 3'b001, 32'hFFFFFFFD, 32'd5, 0, 0, 64'hFFFFFFFF_FFFFFFF1, 34, 0);
        run("multu",    0, 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 64'hFFFFFFFE_00000001, 34, 0);
        run("div",      0, 3'b011, 32'hFFFFFFF9, 32'd2, 0, 0, 64'hFFFFFFFF_FFFFFFFD, 34, 0);
        run("divu",     0, 3'b010, 32'hFFFFFFFF, 32'h10, 0, 0, 64'h0000000F_0FFFFFFF, 34, 0);
        run("divu_z",   0, 3'b010, 32'd5, 32'd0, 0, 0, 64'h00000005_FFFFFFFF, 2, 1);
        run("div_mneg", 0, 3'b011, 32'h80000000, 32'hFFFFFFFF, 0, 0, 64'h00000000_80000000, 34, 0);
        run("msub",     0, 3'b111, 32'd3, 32'd4, 32'h0, 32'h10, 64'h00000000_00000004, 34, 0);
        run("maddu",    0, 3'b100, 32'd1, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 34, 0);
        run("madd",     0, 3'b101, 32'hFFFFFFFE, 32'd3, 0, 0, 64'hFFFFFFFF_FFFFFFFA, 34, 0);
        run("b2b_mult", 1, 3'b000, 32'd7, 32'd6, 0, 0, 64'h2A, 34, 0);
        run("b2b_divu", 1, 3'b010, 32'd100, 32'd7, 0, 0, 64'h00000002_0000000E, 34, 0);

        @(negedge clk);
        issue(3'b000, 32'd9, 32'd9, 0, 0);
        repeat (9) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        check("annul_busy", 64'(bsy1), 64'h0);
        check("annul_ready", 64'(rdy1), 64'h0);
        check("annul_res", res1, 64'h00000002_0000000E);
        run("after_annul", 0, 3'b000, 32'd9, 32'd9, 0, 0, 64'h51, 34, 0);

        @(negedge clk);
        start_i = 1'b1;
        annul_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        annul_i = 1'b0;
        check("annul_vs_start_busy", 64'(bsy1), 64'h0);

        @(negedge clk);
        issue(3'b000, 32'd3, 32'd3, 0, 0);
        repeat (32) @(negedge clk);
        check("fixup_busy", 64'(bsy1), 64'h1);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        check("fixup_annul_ready", 64'(rdy1), 64'h0);
        check("fixup_annul_res", res1, 64'h51);
        check("fixup_annul_busy", 64'(bsy1), 64'h0);

        @(negedge clk);
        issue(3'b011, 32'h80000000, 32'hFFFFFFFF, 0, 0);
        lat = 1;
        while (!rdy4 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("s4_div_lat", 64'(lat), 64'd10);
        check("s4_div_res", res4, 64'h00000000_80000000);

        @(negedge clk);
        issue(3'b000, 32'd3, 32'd3, 0, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("s4_rst_res", res4, 64'h0);
        check("s4_rst_busy", 64'(bsy4), 64'h0);
        check("s4_rst_ready", 64'(rdy4), 64'h0);
        check("s4_rst_dz", 64'(dz4), 64'h0);
        pulses = 0;
        repeat (12) begin
            pulses += int'(rdy4);
            @(negedge clk);
        end
        check("s4_rst_no_ready", 64'(pulses), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
